// File: rtl/core2axi_pkg.sv
// core2axi_pkg: shared constants and types for the core-to-AXI4 bridge.
//   - AXI response encodings and the fixed burst/size/cache attributes
//   - dir_e: direction of the accesses currently in flight
package core2axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] LEN_SINGLE  = 8'd0;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] CACHE_MOD   = 4'b0010;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_e;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/core2axi_lane_fifo.sv
// core2axi_lane_fifo: small synchronous FIFO holding the 32-bit lane index
// of each outstanding read, so the returning R beat can be steered.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, din     write one entry (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   dout          head entry
//   full, empty   status flags
module core2axi_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core2axi_pipe.sv
// core2axi_pipe: bridges a core req/gnt/rvalid data port onto single-beat
// AXI4 transactions with up to MAX_OUTSTANDING accesses of one direction in
// flight. All IDs are 0; ordering is kept by never mixing directions.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   data_*                core side: req/gnt handshake, in-order rvalid+err
//   aw_*, w_*, b_*        AXI4 write address / data / response channels
//   ar_*, r_*             AXI4 read address / data channels
module core2axi_pipe
  import core2axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 16,
  parameter int AXI_USER_WIDTH  = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic                        data_err_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [31:0]                 data_wdata_i,
  output logic [31:0]                 data_rdata_o,
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [7:0]                  aw_len_o,
  output logic [2:0]                  aw_size_o,
  output logic [1:0]                  aw_burst_o,
  output logic                        aw_lock_o,
  output logic [3:0]                  aw_cache_o,
  output logic [2:0]                  aw_prot_o,
  output logic [3:0]                  aw_region_o,
  output logic [AXI_USER_WIDTH-1:0]   aw_user_o,
  output logic [3:0]                  aw_qos_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  output logic [AXI_USER_WIDTH-1:0]   w_user_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
  input  logic [1:0]                  b_resp_i,
  input  logic [AXI_USER_WIDTH-1:0]   b_user_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [7:0]                  ar_len_o,
  output logic [2:0]                  ar_size_o,
  output logic [1:0]                  ar_burst_o,
  output logic                        ar_lock_o,
  output logic [3:0]                  ar_cache_o,
  output logic [2:0]                  ar_prot_o,
  output logic [3:0]                  ar_region_o,
  output logic [AXI_USER_WIDTH-1:0]   ar_user_o,
  output logic [3:0]                  ar_qos_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i,
  input  logic [AXI_USER_WIDTH-1:0]   r_user_i,
  input  logic                        r_valid_i,
  output logic                        r_ready_o
);

  localparam int NLANES = AXI_DATA_WIDTH / 32;
  localparam int OFF    = $clog2(AXI_DATA_WIDTH / 8);
  localparam int LANE_W = (OFF > 2) ? OFF - 2 : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

`ifndef SYNTHESIS
  if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64 && AXI_DATA_WIDTH != 128) begin : g_bad_width
    $error("core2axi_pipe: AXI_DATA_WIDTH must be 32, 64 or 128");
  end
`endif

  logic [CNT_W-1:0]  cnt_q;
  dir_e              dir_q;
  logic              aw_sent_q;
  logic              w_sent_q;
  dir_e              req_dir;
  logic              eligible;
  logic              aw_done;
  logic              w_done;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              r_hs;
  logic              b_hs;
  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] head_lane;
  logic              fifo_full;
  logic              fifo_empty;

  // Fixed AXI attributes.
  assign aw_id_o     = '0;
  assign aw_addr_o   = data_addr_i;
  assign aw_len_o    = LEN_SINGLE;
  assign aw_size_o   = SIZE_4B;
  assign aw_burst_o  = BURST_INCR;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = CACHE_MOD;
  assign aw_prot_o   = 3'b000;
  assign aw_region_o = 4'b0000;
  assign aw_user_o   = '1;
  assign aw_qos_o    = 4'b0000;
  assign ar_id_o     = '0;
  assign ar_addr_o   = data_addr_i;
  assign ar_len_o    = LEN_SINGLE;
  assign ar_size_o   = SIZE_4B;
  assign ar_burst_o  = BURST_INCR;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = CACHE_MOD;
  assign ar_prot_o   = 3'b000;
  assign ar_region_o = 4'b0000;
  assign ar_user_o   = '1;
  assign ar_qos_o    = 4'b0000;
  assign w_last_o    = 1'b1;
  assign w_user_o    = '0;

  // A request may only issue when the counter has room and it does not
  // change direction while earlier responses are still pending.
  assign req_dir  = data_we_i ? DIR_WRITE : DIR_READ;
  assign eligible = data_req_i && (cnt_q < CNT_W'(MAX_OUTSTANDING)) &&
                    ((cnt_q == '0) || (dir_q == req_dir));

  assign ar_valid_o = eligible && !data_we_i;
  assign aw_valid_o = eligible && data_we_i && !aw_sent_q;
  assign w_valid_o  = eligible && data_we_i && !w_sent_q;

  assign aw_done    = aw_sent_q || (aw_valid_o && aw_ready_i);
  assign w_done     = w_sent_q  || (w_valid_o  && w_ready_i);
  assign rd_gnt     = ar_valid_o && ar_ready_i;
  assign wr_gnt     = eligible && data_we_i && aw_done && w_done;
  assign data_gnt_o = rd_gnt || wr_gnt;

  assign r_ready_o = (cnt_q != '0) && (dir_q == DIR_READ);
  assign b_ready_o = (cnt_q != '0) && (dir_q == DIR_WRITE);
  assign r_hs      = r_ready_o && r_valid_i;
  assign b_hs      = b_ready_o && b_valid_i;

  assign data_rvalid_o = r_hs || b_hs;

  // Error flag comes from whichever response channel handshakes.
  always_comb begin
    data_err_o = 1'b0;
    if (r_hs) begin
      data_err_o = resp_is_err(r_resp_i);
    end else if (b_hs) begin
      data_err_o = resp_is_err(b_resp_i);
    end else begin
      data_err_o = 1'b0;
    end
  end

  if (OFF > 2) begin : g_lanes
    assign lane         = data_addr_i[OFF-1:2];
    assign data_rdata_o = r_data_i[{head_lane, 5'b00000} +: 32];
  end else begin : g_single_lane
    assign lane         = 1'b0;
    assign data_rdata_o = r_data_i[31:0];
  end

  assign w_data_o = {NLANES{data_wdata_i}};
  assign w_strb_o = (AXI_DATA_WIDTH/8)'(data_be_i) << {lane, 2'b00};

  core2axi_lane_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (LANE_W)
  ) u_lane_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (rd_gnt),
    .din   (lane),
    .pop   (r_hs),
    .dout  (head_lane),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outstanding count, current direction and early AW/W completion flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      dir_q     <= DIR_READ;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else begin
      case ({data_gnt_o, data_rvalid_o})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (data_gnt_o) begin
        dir_q <= req_dir;
      end
      if (wr_gnt) begin
        aw_sent_q <= 1'b0;
        w_sent_q  <= 1'b0;
      end else begin
        if (aw_valid_o && aw_ready_i) begin
          aw_sent_q <= 1'b1;
        end
        if (w_valid_o && w_ready_i) begin
          w_sent_q <= 1'b1;
        end
      end
    end
  end

  // IDs, user fields, r_last and status flags carry no information here.
  logic unused_sink;
  assign unused_sink = ^{b_id_i, b_user_i, r_id_i, r_last_i, r_user_i,
                         fifo_full, fifo_empty};

endmodule

// File: tb/tb_core2axi_pipe.sv
module tb_core2axi_pipe;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         data_req_i;
  logic         data_gnt_o;
  logic         data_rvalid_o;
  logic         data_err_o;
  logic [31:0]  data_addr_i;
  logic         data_we_i;
  logic [3:0]   data_be_i;
  logic [31:0]  data_wdata_i;
  logic [31:0]  data_rdata_o;
  logic [15:0]  aw_id_o;
  logic [31:0]  aw_addr_o;
  logic [7:0]   aw_len_o;
  logic [2:0]   aw_size_o;
  logic [1:0]   aw_burst_o;
  logic         aw_lock_o;
  logic [3:0]   aw_cache_o;
  logic [2:0]   aw_prot_o;
  logic [3:0]   aw_region_o;
  logic [9:0]   aw_user_o;
  logic [3:0]   aw_qos_o;
  logic         aw_valid_o;
  logic         aw_ready_i;
  logic [63:0]  w_data_o;
  logic [7:0]   w_strb_o;
  logic         w_last_o;
  logic [9:0]   w_user_o;
  logic         w_valid_o;
  logic         w_ready_i;
  logic [15:0]  b_id_i;
  logic [1:0]   b_resp_i;
  logic [9:0]   b_user_i;
  logic         b_valid_i;
  logic         b_ready_o;
  logic [15:0]  ar_id_o;
  logic [31:0]  ar_addr_o;
  logic [7:0]   ar_len_o;
  logic [2:0]   ar_size_o;
  logic [1:0]   ar_burst_o;
  logic         ar_lock_o;
  logic [3:0]   ar_cache_o;
  logic [2:0]   ar_prot_o;
  logic [3:0]   ar_region_o;
  logic [9:0]   ar_user_o;
  logic [3:0]   ar_qos_o;
  logic         ar_valid_o;
  logic         ar_ready_i;
  logic [15:0]  r_id_i;
  logic [63:0]  r_data_i;
  logic [1:0]   r_resp_i;
  logic         r_last_i;
  logic [9:0]   r_user_i;
  logic         r_valid_i;
  logic         r_ready_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core2axi_pipe #(
    .AXI_ADDR_WIDTH  (32),
    .AXI_DATA_WIDTH  (64),
    .AXI_ID_WIDTH    (16),
    .AXI_USER_WIDTH  (10),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_err_o    (data_err_o),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .aw_id_o       (aw_id_o),
    .aw_addr_o     (aw_addr_o),
    .aw_len_o      (aw_len_o),
    .aw_size_o     (aw_size_o),
    .aw_burst_o    (aw_burst_o),
    .aw_lock_o     (aw_lock_o),
    .aw_cache_o    (aw_cache_o),
    .aw_prot_o     (aw_prot_o),
    .aw_region_o   (aw_region_o),
    .aw_user_o     (aw_user_o),
    .aw_qos_o      (aw_qos_o),
    .aw_valid_o    (aw_valid_o),
    .aw_ready_i    (aw_ready_i),
    .w_data_o      (w_data_o),
    .w_strb_o      (w_strb_o),
    .w_last_o      (w_last_o),
    .w_user_o      (w_user_o),
    .w_valid_o     (w_valid_o),
    .w_ready_i     (w_ready_i),
    .b_id_i        (b_id_i),
    .b_resp_i      (b_resp_i),
    .b_user_i      (b_user_i),
    .b_valid_i     (b_valid_i),
    .b_ready_o     (b_ready_o),
    .ar_id_o       (ar_id_o),
    .ar_addr_o     (ar_addr_o),
    .ar_len_o      (ar_len_o),
    .ar_size_o     (ar_size_o),
    .ar_burst_o    (ar_burst_o),
    .ar_lock_o     (ar_lock_o),
    .ar_cache_o    (ar_cache_o),
    .ar_prot_o     (ar_prot_o),
    .ar_region_o   (ar_region_o),
    .ar_user_o     (ar_user_o),
    .ar_qos_o      (ar_qos_o),
    .ar_valid_o    (ar_valid_o),
    .ar_ready_i    (ar_ready_i),
    .r_id_i        (r_id_i),
    .r_data_i      (r_data_i),
    .r_resp_i      (r_resp_i),
    .r_last_i      (r_last_i),
    .r_user_i      (r_user_i),
    .r_valid_i     (r_valid_i),
    .r_ready_o     (r_ready_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks are taken 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_i = 1'b1;
    data_req_i = 1'b0; data_addr_i = 32'h0; data_we_i = 1'b0;
    data_be_i = 4'h0; data_wdata_i = 32'h0;
    aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
    b_id_i = 16'h0; b_resp_i = 2'b00; b_user_i = 10'h0; b_valid_i = 1'b0;
    r_id_i = 16'h0; r_data_i = 64'h0; r_resp_i = 2'b00; r_last_i = 1'b1;
    r_user_i = 10'h0; r_valid_i = 1'b0;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    settle();
    chk("rst_gnt",    data_gnt_o,    1'b0);
    chk("rst_rvalid", data_rvalid_o, 1'b0);
    chk("rst_arv",    ar_valid_o,    1'b0);
    chk("rst_awv",    aw_valid_o,    1'b0);
    chk("rst_wv",     w_valid_o,     1'b0);
    chk("rst_rrdy",   r_ready_o,     1'b0);
    chk("rst_brdy",   b_ready_o,     1'b0);

    // ---- single read at 0x104 (upper lane), 0-cycle grant
    next_cycle();
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0104; ar_ready_i = 1'b1;
    settle();
    chk("rd1_arv",   ar_valid_o, 1'b1);
    chk("rd1_gnt",   data_gnt_o, 1'b1);
    chk("rd1_addr",  ar_addr_o,  32'h0000_0104);
    chk("rd1_size",  ar_size_o,  3'b010);
    chk("rd1_burst", ar_burst_o, 2'b01);
    chk("rd1_cache", ar_cache_o, 4'b0010);
    chk("rd1_user",  ar_user_o,  10'h3ff);
    chk("rd1_len",   ar_len_o,   8'h00);
    chk("rd1_id",    ar_id_o,    16'h0000);
    next_cycle();
    data_req_i = 1'b0; ar_ready_i = 1'b0;
    settle();
    chk("rd1_rrdy", r_ready_o, 1'b1);
    chk("rd1_brdy", b_ready_o, 1'b0);
    next_cycle();
    r_valid_i = 1'b1; r_data_i = 64'hAAAA_BBBB_CCCC_DDDD; r_resp_i = 2'b00;
    settle();
    chk("rd1_rvalid", data_rvalid_o, 1'b1);
    chk("rd1_rdata",  data_rdata_o,  32'hAAAA_BBBB);
    chk("rd1_err",    data_err_o,    1'b0);
    next_cycle();
    r_valid_i = 1'b0;
    settle();
    chk("rd1_rrdy_done", r_ready_o, 1'b0);

    // ---- write 0x208 be=0011, W accepted at once, AW 3 cycles late
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0000_0208;
    data_be_i = 4'b0011; data_wdata_i = 32'h1234_5678; w_ready_i = 1'b1;
    settle();
    chk("wr1_awv0",  aw_valid_o, 1'b1);
    chk("wr1_wv0",   w_valid_o,  1'b1);
    chk("wr1_strb",  w_strb_o,   8'h03);
    chk("wr1_wdata", w_data_o,   64'h1234_5678_1234_5678);
    chk("wr1_wlast", w_last_o,   1'b1);
    chk("wr1_gnt0",  data_gnt_o, 1'b0);
    next_cycle();
    settle();
    chk("wr1_wv1",  w_valid_o,  1'b0);
    chk("wr1_awv1", aw_valid_o, 1'b1);
    chk("wr1_gnt1", data_gnt_o, 1'b0);
    next_cycle();
    settle();
    chk("wr1_wv2",  w_valid_o,  1'b0);
    chk("wr1_gnt2", data_gnt_o, 1'b0);
    next_cycle();
    aw_ready_i = 1'b1;
    settle();
    chk("wr1_wv3",  w_valid_o,  1'b0);
    chk("wr1_gnt3", data_gnt_o, 1'b1);
    next_cycle();
    data_req_i = 1'b0; aw_ready_i = 1'b0; w_ready_i = 1'b0;
    settle();
    chk("wr1_brdy", b_ready_o,  1'b1);
    chk("wr1_awv4", aw_valid_o, 1'b0);
    next_cycle();
    b_valid_i = 1'b1; b_resp_i = 2'b00;
    settle();
    chk("wr1_rvalid", data_rvalid_o, 1'b1);
    chk("wr1_err",    data_err_o,    1'b0);
    next_cycle();
    b_valid_i = 1'b0;

    // ---- write 0x20C be=1100: AW first, W one cycle later
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0000_020C;
    data_be_i = 4'b1100; aw_ready_i = 1'b1; w_ready_i = 1'b0;
    settle();
    chk("wr2_strb", w_strb_o,   8'hC0);
    chk("wr2_gnt0", data_gnt_o, 1'b0);
    next_cycle();
    w_ready_i = 1'b1;
    settle();
    chk("wr2_awv1", aw_valid_o, 1'b0);
    chk("wr2_wv1",  w_valid_o,  1'b1);
    chk("wr2_gnt1", data_gnt_o, 1'b1);
    next_cycle();
    data_req_i = 1'b0; aw_ready_i = 1'b0; w_ready_i = 1'b0;
    b_valid_i = 1'b1; b_resp_i = 2'b00;
    settle();
    chk("wr2_rvalid", data_rvalid_o, 1'b1);
    next_cycle();
    b_valid_i = 1'b0;

    // ---- four back-to-back reads, fifth stalls until the first R
    ar_ready_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_addr_i = 32'(i * 4);
      settle();
      chk($sformatf("b2b_gnt%0d", i), data_gnt_o, 1'b1);
      next_cycle();
    end
    data_addr_i = 32'h0000_0010;
    settle();
    chk("b2b_stall_gnt", data_gnt_o, 1'b0);
    chk("b2b_stall_arv", ar_valid_o, 1'b0);
    next_cycle();
    r_valid_i = 1'b1; r_resp_i = 2'b00; r_data_i = 64'h1111_0001_0000_0001;
    settle();
    chk("b2b_r1_rvalid", data_rvalid_o, 1'b1);
    chk("b2b_r1_rdata",  data_rdata_o,  32'h0000_0001);
    chk("b2b_r1_gnt",    data_gnt_o,    1'b0);
    next_cycle();
    r_valid_i = 1'b0;
    settle();
    chk("b2b_5th_gnt", data_gnt_o, 1'b1);
    next_cycle();
    data_req_i = 1'b0; ar_ready_i = 1'b0;
    r_valid_i = 1'b1; r_data_i = 64'h2222_2222_2020_2020;
    settle();
    chk("b2b_r2_rdata", data_rdata_o, 32'h2222_2222);
    next_cycle();
    r_data_i = 64'h3333_3333_3030_3030;
    settle();
    chk("b2b_r3_rdata", data_rdata_o, 32'h3030_3030);
    next_cycle();
    r_data_i = 64'h4444_4444_4040_4040;
    settle();
    chk("b2b_r4_rdata", data_rdata_o, 32'h4444_4444);
    chk("b2b_r4_err",   data_err_o,   1'b0);
    next_cycle();
    r_data_i = 64'h5555_5555_5050_5050; r_resp_i = 2'b10;
    settle();
    chk("b2b_r5_rdata", data_rdata_o,  32'h5050_5050);
    chk("b2b_r5_err",   data_err_o,    1'b1);
    chk("b2b_r5_valid", data_rvalid_o, 1'b1);
    next_cycle();
    r_valid_i = 1'b0; r_resp_i = 2'b00;
    settle();
    chk("b2b_drained_rrdy", r_ready_o, 1'b0);

    // ---- read outstanding, then a write must wait for it to retire
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0000; ar_ready_i = 1'b1;
    settle();
    chk("dir_rd_gnt", data_gnt_o, 1'b1);
    next_cycle();
    ar_ready_i = 1'b0; data_we_i = 1'b1; data_addr_i = 32'h0000_0020;
    data_be_i = 4'hF; aw_ready_i = 1'b1; w_ready_i = 1'b1;
    settle();
    chk("dir_awv0", aw_valid_o, 1'b0);
    chk("dir_wv0",  w_valid_o,  1'b0);
    chk("dir_gnt0", data_gnt_o, 1'b0);
    next_cycle();
    r_valid_i = 1'b1; r_data_i = 64'h0;
    settle();
    chk("dir_awv1",   aw_valid_o,    1'b0);
    chk("dir_rvalid", data_rvalid_o, 1'b1);
    next_cycle();
    r_valid_i = 1'b0;
    settle();
    chk("dir_awv2", aw_valid_o, 1'b1);
    chk("dir_wv2",  w_valid_o,  1'b1);
    chk("dir_strb", w_strb_o,   8'h0F);
    chk("dir_gnt2", data_gnt_o, 1'b1);
    next_cycle();
    data_req_i = 1'b0; aw_ready_i = 1'b0; w_ready_i = 1'b0;
    b_valid_i = 1'b1; b_resp_i = 2'b11;
    settle();
    chk("decerr_rvalid", data_rvalid_o, 1'b1);
    chk("decerr_err",    data_err_o,    1'b1);
    next_cycle();
    b_valid_i = 1'b0; b_resp_i = 2'b00;

    // ---- reset with two reads outstanding
    data_req_i = 1'b1; data_we_i = 1'b0; ar_ready_i = 1'b1; data_addr_i = 32'h0000_0000;
    next_cycle();
    data_addr_i = 32'h0000_0008;
    next_cycle();
    data_req_i = 1'b0; ar_ready_i = 1'b0; rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0; r_valid_i = 1'b1; r_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
    settle();
    chk("mrst_rrdy",   r_ready_o,     1'b0);
    chk("mrst_rvalid", data_rvalid_o, 1'b0);
    chk("mrst_arv",    ar_valid_o,    1'b0);
    chk("mrst_awv",    aw_valid_o,    1'b0);
    chk("mrst_brdy",   b_ready_o,     1'b0);
    next_cycle();
    r_valid_i = 1'b0;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0004; ar_ready_i = 1'b1;
    settle();
    chk("mrst_new_gnt", data_gnt_o, 1'b1);
    next_cycle();
    data_req_i = 1'b0; ar_ready_i = 1'b0;
    r_valid_i = 1'b1; r_data_i = 64'hCAFE_0001_BEEF_0002;
    settle();
    chk("mrst_new_rdata", data_rdata_o, 32'hCAFE_0001);
    next_cycle();
    r_valid_i = 1'b0;
    settle();
    chk("mrst_idle_rrdy", r_ready_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core2axi_pipe.md
Name: core2axi_pipe

Overview:
Parametrised successor of the single-outstanding core-to-AXI4 bridge. It converts the core's req/gnt/rvalid data port into single-beat AXI4 transactions. It supports up to MAX_OUTSTANDING in-flight accesses of one direction, AXI data widths of 32/64/128 with lane steering, and reports error responses to the core. It sits between a core's data port and the cluster AXI crossbar.

Parameters:
AXI_ADDR_WIDTH, 32, address width
AXI_DATA_WIDTH, 64, AXI data width; legal values 32, 64, 128
AXI_ID_WIDTH, 16, ID width; IDs are always driven 0
AXI_USER_WIDTH, 10, user width
MAX_OUTSTANDING, 4, max in-flight transactions, power of 2, at least 1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
data_req_i  in  1  core request; held stable until gnt
data_gnt_o  out  1  request accepted
data_rvalid_o  out  1  response, one per grant, in order
data_err_o  out  1  qualifies rvalid; 1 on SLVERR/DECERR
data_addr_i  in  AXI_ADDR_WIDTH  byte address
data_we_i  in  1  1=write
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_rdata_o  out  32  read data, valid with rvalid
aw_*/ar_* (id, addr, len, size, burst, lock, cache, prot, region, user, qos, valid)  out  standard AXI4  address channels
aw_ready_i, ar_ready_i  in  1  address handshakes
w_data_o  out  AXI_DATA_WIDTH  replicated wdata
w_strb_o  out  AXI_DATA_WIDTH/8  lane-steered be
w_last_o  out  1  constant 1
w_user_o  out  AXI_USER_WIDTH  constant 0
w_valid_o  out  1
w_ready_i  in  1
b_id_i, b_resp_i, b_user_i, b_valid_i  in  standard  write response
b_ready_o  out  1
r_id_i, r_data_i, r_resp_i, r_last_i, r_user_i, r_valid_i  in  standard  read response
r_ready_o  out  1

Behaviour:
- Reset, sync, rst_i=1 at posedge: cnt_q=0, dir_q=read, aw_sent_q=w_sent_q=0, lane FIFO empty. All valid/ready/gnt/rvalid/err outputs are 0 while cnt_q=0 and no request is pending.
- Constants: len=0, size=3'b010, burst=INCR(01), cache=4'b0010, user='1 on aw/ar, lock/prot/region/qos/id=0, aw/ar_addr=data_addr_i.
- Eligible = data_req_i && cnt_q<MAX_OUTSTANDING && (cnt_q==0 || dir_q==data_we_i). A direction switch stalls until all earlier responses have retired. This guarantees in-order responses with ID 0.
- Read: ar_valid_o=eligible&&!we. gnt=ar_valid_o&&ar_ready_i in the same cycle (0-cycle grant). On gnt, push addr[OFF-1:2] into the lane FIFO, where OFF=log2(AXI_DATA_WIDTH/8).
- Write: aw_valid_o=eligible&&we&&!aw_sent_q; w_valid_o=eligible&&we&&!w_sent_q. AW and W may complete in either order or the same cycle. Record early completions in aw_sent_q/w_sent_q. gnt is asserted in the cycle the second of the two completes; both flags then clear.
- w_strb_o = data_be_i shifted to lane addr[OFF-1:2], other lanes 0. w_data_o = wdata replicated across all lanes.
- Responses: r_ready_o=(cnt_q!=0 && dir_q==read); b_ready_o=(cnt_q!=0 && dir_q==write). A response with cnt_q==0 is not accepted; it stays stalled.
- data_rvalid_o = r handshake or b handshake, combinational, same cycle. data_rdata_o = selected lane of r_data_i using the FIFO head; the FIFO pops on r handshake. data_err_o=resp[1]. r_last_i and IDs are ignored.
- cnt_q: +1 on gnt, -1 on response. Simultaneous gnt and response holds the count. The full check uses cnt_q, so there is no same-cycle bypass. dir_q loads data_we_i on gnt.
- Reset mid-transaction drops all state. The fabric must be reset together with this block.
- Illegal AXI_DATA_WIDTH: $error under ifndef SYNTHESIS.

Decomposition:
- Package core2axi_pkg: resp encodings (OKAY/EXOKAY/SLVERR/DECERR), burst/size/cache constants, dir_e enum.
- Sub-module core2axi_lane_fifo: parametrised depth/width sync FIFO with push/pop/full/empty, in the same reset style.

Test Plan:
- Read at 0x104, W=64, ar_ready=1, R returns data 0xAAAA_BBBB_CCCC_DDDD OKAY two cycles later -> gnt same cycle as req; rvalid with rdata=0xAAAA_BBBB, err=0.
- Write 0x208, be=4'b0011, W=64, aw_ready late by 3 cycles, w_ready immediate -> w fires once, strb=0x03, gnt on the aw cycle, rvalid on b.
- Four back-to-back reads with R held off -> 4 grants, 5th req stalls (gnt=0, ar_valid=0) until the first R, then grants in the response cycle+1. Responses in order.
- Read outstanding followed by a write request -> no aw/w valid until the read retires; the write then grants.
- B with resp=DECERR -> rvalid=1, err=1. R with SLVERR -> err=1, cnt decrements.
- rst_i asserted with 2 reads outstanding -> next cycle cnt=0, all valids 0, r_ready=0.
